// File: rtl/result_readout.sv
// Reads stored results from the register file in index order and streams each one
// as two bytes, high byte first. After the last result it clears the file, then pulses done.
module result_readout #(
  parameter int NUM_RESULTS = 10,
  parameter int SEL_W       = 4,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  count,
  output logic [SEL_W-1:0]  out_sel,
  input  logic [DATA_W-1:0] out_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              clear_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_HI,
    SEND_LO,
    CLEAR,
    DONE
  } state_t;

  localparam logic [SEL_W-1:0] MAX_LAST = SEL_W'(NUM_RESULTS - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  index, index_nxt;
  logic [SEL_W-1:0]  last, last_nxt;
  logic [DATA_W-1:0] hold;

  // Index of the final result to send; requests beyond the file size saturate.
  function automatic logic [SEL_W-1:0] clamp_last(input logic [SEL_W-1:0] n);
    if (int'(n) >= NUM_RESULTS) begin
      return MAX_LAST;
    end
    return n - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      index <= '0;
      last  <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      last  <= last_nxt;
    end
  end

  // The register file read is combinational, so the word is captured while LOAD drives the select.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold <= '0;
    end else if (state == LOAD) begin
      hold <= out_data;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (start) begin
          index_nxt = '0;
          if (count != '0) begin
            last_nxt  = clamp_last(count);
            state_nxt = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD:    state_nxt = SEND_HI;
      SEND_HI: begin
        if (tx_ready) state_nxt = SEND_LO;
      end
      SEND_LO: begin
        if (tx_ready) begin
          if (index == last) begin
            state_nxt = CLEAR;
          end else begin
            index_nxt = index + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      CLEAR:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode: every output depends only on registered state, index and hold.
  always_comb begin
    out_sel    = '0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    clear_data = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      LOAD: out_sel = index;
      SEND_HI: begin
        out_sel  = index;
        tx_valid = 1'b1;
        tx_data  = hold[15:8];
      end
      SEND_LO: begin
        out_sel  = index;
        tx_valid = 1'b1;
        tx_data  = hold[7:0];
      end
      CLEAR: begin
        out_sel    = index;
        clear_data = 1'b1;
      end
      DONE: begin
        out_sel = index;
        done    = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_result_readout.sv
// Bench for result_readout: table-driven runs plus randomized runs against a byte-stream
// model of the register file contents, and a hand-written mid-run reset sequence.
module tb_result_readout;

  localparam int NUM = 10;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [3:0]  count;
  logic [3:0]  out_sel;
  logic [15:0] out_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        clear_data;
  logic        busy;
  logic        done;

  logic [15:0] regs [NUM];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign out_data = (out_sel < 4'(NUM)) ? regs[out_sel] : 16'hDEAD;

  result_readout #(.NUM_RESULTS(NUM), .SEL_W(4), .DATA_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .count(count),
    .out_sel(out_sel), .out_data(out_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .clear_data(clear_data), .busy(busy), .done(done)
  );

  typedef struct {
    int cnt;
    int stall;
    int pat;
    int repulse;
    bit rnd;
    int exp_bytes;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fill_regs(input int pat);
    for (int i = 0; i < NUM; i++) begin
      case (pat)
        0:       regs[i] = (i == 0) ? 16'h1234 : (i == 1) ? 16'hABCD : 16'($urandom);
        1:       regs[i] = 16'(i * 16'h0101);
        default: regs[i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(tx_valid == 1'b0 && tx_data == 8'h00, {tag, "_tx"}, {tx_valid, tx_data}, 0);
    chk(clear_data == 1'b0 && done == 1'b0 && busy == 1'b0, {tag, "_ctl"},
        {clear_data, done, busy}, 0);
    chk(out_sel == 4'd0, {tag, "_sel"}, out_sel, 0);
  endtask

  task automatic run(input vec_t v, input string name);
    logic [7:0] expq[$];
    int n, cyc, stall_cnt, stalls, nbytes, clear_cyc, done_cyc, exp_done, sel_max;
    bit stall_now;
    n = (v.cnt > NUM) ? NUM : v.cnt;
    for (int i = 0; i < n; i++) begin
      expq.push_back(regs[i][15:8]);
      expq.push_back(regs[i][7:0]);
    end
    stall_cnt = 0; stalls = 0; nbytes = 0; clear_cyc = 0; done_cyc = 0; sel_max = 0;
    @(negedge clk);
    start = 1'b1; count = 4'(v.cnt); tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; count = 4'($urandom);
    for (cyc = 1; cyc <= 400; cyc++) begin
      start = (cyc == v.repulse);
      chk(busy == 1'b1, {name, "_busy"}, busy, 1);
      if (int'(out_sel) > sel_max) sel_max = int'(out_sel);
      if (clear_data) clear_cyc = cyc;
      if (tx_valid) begin
        if (expq.size() == 0) begin
          chk(1'b0, {name, "_extra_byte"}, tx_data, 0);
          tx_ready = 1'b1;
        end else begin
          chk(tx_data == expq[0], {name, "_byte"}, tx_data, expq[0]);
          stall_now = v.rnd ? ($urandom_range(0, 2) == 0) : (stall_cnt < v.stall);
          if (stall_now) begin
            tx_ready = 1'b0; stall_cnt++; stalls++;
          end else begin
            tx_ready = 1'b1; stall_cnt = 0; nbytes++;
            void'(expq.pop_front());
          end
        end
      end else begin
        chk(tx_data == 8'h00, {name, "_data_idle"}, tx_data, 0);
        tx_ready = 1'($urandom);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_done = (n == 0) ? 1 : 3 * n + 2 + stalls;
    chk(done_cyc == exp_done, {name, "_done_cycle"}, done_cyc, exp_done);
    chk(nbytes == 2 * n, {name, "_nbytes"}, nbytes, 2 * n);
    chk(clear_cyc == ((n == 0) ? 0 : exp_done - 1), {name, "_clear_cycle"}, clear_cyc,
        (n == 0) ? 0 : exp_done - 1);
    chk(sel_max <= NUM - 1, {name, "_sel_max"}, sel_max, NUM - 1);
    if (!v.rnd) begin
      chk(done_cyc == v.exp_done, {name, "_tbl_done"}, done_cyc, v.exp_done);
      chk(nbytes == v.exp_bytes, {name, "_tbl_bytes"}, nbytes, v.exp_bytes);
    end
    @(negedge clk);
    check_idle_outputs({name, "_after"});
  endtask

  initial begin
    int rst_cyc;
    bit saw_clear;
    logic [15:0] snap3, snap0;
    n_rst = 1'b0; start = 1'b0; count = '0; tx_ready = 1'b0;
    fill_regs(2);
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    vecs[0] = '{cnt: 2,  stall: 0, pat: 0, repulse: 0, rnd: 0, exp_bytes: 4,  exp_done: 8};
    vecs[1] = '{cnt: 2,  stall: 3, pat: 0, repulse: 0, rnd: 0, exp_bytes: 4,  exp_done: 20};
    vecs[2] = '{cnt: 15, stall: 0, pat: 1, repulse: 0, rnd: 0, exp_bytes: 20, exp_done: 32};
    vecs[3] = '{cnt: 0,  stall: 0, pat: 2, repulse: 0, rnd: 0, exp_bytes: 0,  exp_done: 1};
    vecs[4] = '{cnt: 2,  stall: 0, pat: 0, repulse: 3, rnd: 0, exp_bytes: 4,  exp_done: 8};
    vecs[5] = '{cnt: 1,  stall: 0, pat: 2, repulse: 0, rnd: 0, exp_bytes: 2,  exp_done: 5};
    vecs[6] = '{cnt: 10, stall: 1, pat: 2, repulse: 0, rnd: 0, exp_bytes: 20, exp_done: 52};
    vecs[7] = '{cnt: 3,  stall: 2, pat: 2, repulse: 5, rnd: 0, exp_bytes: 6,  exp_done: 23};

    for (int i = 0; i < 8; i++) begin
      fill_regs(vecs[i].pat);
      run(vecs[i], $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 20; r++) begin
      vec_t rv;
      rv = '{cnt: int'($urandom_range(0, 15)), stall: 0, pat: 2,
             repulse: int'($urandom_range(0, 12)), rnd: 1, exp_bytes: -1, exp_done: -1};
      fill_regs(2);
      run(rv, $sformatf("rnd%0d", r));
    end

    // Reset during the high byte of result 3 with the link always ready.
    fill_regs(2);
    snap0 = regs[0]; snap3 = regs[3];
    saw_clear = 1'b0;
    @(negedge clk);
    start = 1'b1; count = 4'd5; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (rst_cyc = 1; rst_cyc < 11; rst_cyc++) begin
      if (clear_data) saw_clear = 1'b1;
      @(negedge clk);
    end
    chk(tx_valid == 1'b1 && tx_data == snap3[15:8], "rst_pre_hi", tx_data, snap3[15:8]);
    chk(out_sel == 4'd3, "rst_pre_sel", out_sel, 3);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    repeat (3) begin
      @(negedge clk);
      if (clear_data || done) saw_clear = 1'b1;
    end
    chk(saw_clear == 1'b0, "rst_no_clear", saw_clear, 0);
    chk(out_data == snap0 && regs[3] == snap3, "rst_regs_intact", out_data, snap0);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
